ring_router_q: RTL and testbench

// - Parametrised successor to the inter-cluster ring router for Ara slides/reductions.
// - Adds input FIFOs, a TEE mode (deliver to SLDU and forward), and a beat-counted config FSM.
// - One instance sits per cluster between the SLDU and its left and right ring neighbours.

---
 rtl/ring_router_q.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ring_router_q.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_router_q.sv
// Per-cluster ring router: two input FIFOs, two spill-register ring outputs, LOCAL/BYPASS/TEE routing.
// Optional perf counters (perf_fwd_cnt_o, perf_stall_cnt_o) when RING_ROUTER_PERF_CNT_EN is defined.
module ring_router_q #(
  parameter int unsigned DataWidth = 64,
  parameter int unsigned FifoDepth = 4,
  parameter int unsigned LenWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 conf_valid_i,
  output logic                 conf_ready_o,
  input  logic                 conf_dir_i,
  input  logic [1:0]           conf_mode_i,
  input  logic [LenWidth-1:0]  conf_len_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic [DataWidth-1:0] sldu_i,
  input  logic                 sldu_valid_i,
  output logic                 sldu_ready_o,
  output logic [DataWidth-1:0] sldu_o,
  output logic                 sldu_valid_o,
  input  logic                 sldu_ready_i,
  input  logic [DataWidth-1:0] ring_left_i,
  input  logic                 ring_left_valid_i,
  output logic                 ring_left_ready_o,
  input  logic [DataWidth-1:0] ring_right_i,
  input  logic                 ring_right_valid_i,
  output logic                 ring_right_ready_o,
  output logic [DataWidth-1:0] ring_left_o,
  output logic                 ring_left_valid_o,
  input  logic                 ring_left_ready_i,
  output logic [DataWidth-1:0] ring_right_o,
  output logic                 ring_right_valid_o,
  input  logic                 ring_right_ready_i
`ifdef RING_ROUTER_PERF_CNT_EN
  ,
  output logic [31:0]          perf_fwd_cnt_o,
  output logic [31:0]          perf_stall_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(FifoDepth);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};
  localparam logic [1:0] MODE_LOCAL = 2'b00;
  localparam logic [1:0] MODE_TEE   = 2'b10;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e              state_q;
  logic                dir_q;
  logic [1:0]          mode_q;
  logic [LenWidth-1:0] cnt_q;
  logic                done_len0_q;
  logic                taken_sldu_q, taken_dn_q;
  logic                taken_sldu_d, taken_dn_d;

  // Port index 0 = left, 1 = right for all per-port arrays below.
  logic [DataWidth-1:0] in_data [2];
  logic [1:0]           in_valid;
  logic [1:0]           out_ready;

  logic [DataWidth-1:0] fifo_mem_q [2][FifoDepth];
  logic [AW:0]          wr_ptr_q [2];
  logic [AW:0]          rd_ptr_q [2];
  logic [1:0]           fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DataWidth-1:0] fifo_head [2];

  logic [DataWidth-1:0] sp_a_q [2];
  logic [DataWidth-1:0] sp_b_q [2];
  logic [1:0]           sp_a_full_q, sp_b_full_q;
  logic [1:0]           sp_push, sp_pop;

  logic                 up_sel, dn_sel, active, head_valid, dn_room;
  logic [DataWidth-1:0] head_data, dn_data;
  logic                 sldu_valid, sldu_rdy, dn_push, up_pop, sldu_got, dn_got;
  logic                 conf_accept, drain_done;

  assign in_data[0] = ring_left_i;
  assign in_data[1] = ring_right_i;
  assign in_valid   = {ring_right_valid_i, ring_left_valid_i};
  assign out_ready  = {ring_right_ready_i, ring_left_ready_i};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                      (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
      fifo_head[i]  = fifo_mem_q[i][rd_ptr_q[i][AW-1:0]];
    end
  end

  assign fifo_push = in_valid & ~fifo_full;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (fifo_push[i]) fifo_mem_q[i][wr_ptr_q[i][AW-1:0]] <= in_data[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (fifo_push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrOne;
        if (fifo_pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrOne;
      end
    end
  end

  // Upstream is the neighbour data flows from: right for slidedown, left for slideup.
  assign up_sel     = ~dir_q;
  assign dn_sel     = dir_q;
  assign active     = (state_q == ACTIVE);
  assign head_valid = active & ~fifo_empty[up_sel];
  assign head_data  = fifo_head[up_sel];
  assign dn_room    = ~sp_b_full_q[dn_sel];

  always_comb begin
    sldu_valid   = 1'b0;
    sldu_rdy     = 1'b0;
    dn_push      = 1'b0;
    dn_data      = head_data;
    up_pop       = 1'b0;
    sldu_got     = 1'b0;
    dn_got       = 1'b0;
    taken_sldu_d = taken_sldu_q;
    taken_dn_d   = taken_dn_q;
    case (mode_q)
      MODE_LOCAL: begin
        sldu_valid = head_valid;
        up_pop     = head_valid & sldu_ready_i;
        sldu_rdy   = active & dn_room;
        dn_push    = sldu_valid_i & sldu_rdy;
        dn_data    = sldu_i;
      end
      MODE_TEE: begin
        // The head leaves the FIFO only once both destinations have it, possibly in different cycles.
        sldu_valid   = head_valid & ~taken_sldu_q;
        dn_push      = head_valid & ~taken_dn_q & dn_room;
        sldu_got     = taken_sldu_q | (sldu_valid & sldu_ready_i);
        dn_got       = taken_dn_q | dn_push;
        up_pop       = head_valid & sldu_got & dn_got;
        taken_sldu_d = sldu_got & ~up_pop;
        taken_dn_d   = dn_got & ~up_pop;
      end
      default: begin
        dn_push = head_valid & dn_room;
        up_pop  = dn_push;
      end
    endcase
  end

  assign fifo_pop = up_sel ? {up_pop, 1'b0} : {1'b0, up_pop};
  assign sp_push  = dn_sel ? {dn_push, 1'b0} : {1'b0, dn_push};
  assign sp_pop   = sp_a_full_q & out_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_a_full_q <= '0;
      sp_b_full_q <= '0;
      for (int i = 0; i < 2; i++) begin
        sp_a_q[i] <= '0;
        sp_b_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sp_pop[i]) begin
          if (sp_b_full_q[i]) begin
            sp_a_q[i]      <= sp_b_q[i];
            sp_b_full_q[i] <= 1'b0;
          end else if (sp_push[i]) begin
            sp_a_q[i] <= dn_data;
          end else begin
            sp_a_full_q[i] <= 1'b0;
          end
        end else if (sp_push[i]) begin
          if (!sp_a_full_q[i]) begin
            sp_a_q[i]      <= dn_data;
            sp_a_full_q[i] <= 1'b1;
          end else begin
            sp_b_q[i]      <= dn_data;
            sp_b_full_q[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign conf_accept = conf_valid_i & (state_q == IDLE);
  assign drain_done  = (state_q == DRAIN) & ~sp_a_full_q[dn_sel] & ~sp_b_full_q[dn_sel];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      dir_q        <= 1'b0;
      mode_q       <= MODE_LOCAL;
      cnt_q        <= '0;
      done_len0_q  <= 1'b0;
      taken_sldu_q <= 1'b0;
      taken_dn_q   <= 1'b0;
    end else begin
      done_len0_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (conf_valid_i) begin
            dir_q        <= conf_dir_i;
            mode_q       <= conf_mode_i;
            cnt_q        <= conf_len_i;
            taken_sldu_q <= 1'b0;
            taken_dn_q   <= 1'b0;
            if (conf_len_i == '0) done_len0_q <= 1'b1;
            else                  state_q     <= ACTIVE;
          end
        end
        ACTIVE: begin
          taken_sldu_q <= taken_sldu_d;
          taken_dn_q   <= taken_dn_d;
          if (up_pop) begin
            cnt_q <= cnt_q - LenWidth'(1);
            if (cnt_q == LenWidth'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign conf_ready_o       = (state_q == IDLE);
  assign busy_o             = (state_q != IDLE);
  assign done_o             = drain_done | done_len0_q;
  assign sldu_ready_o       = sldu_rdy;
  assign sldu_valid_o       = sldu_valid;
  assign sldu_o             = sldu_valid ? head_data : '0;
  assign ring_left_ready_o  = ~fifo_full[0];
  assign ring_right_ready_o = ~fifo_full[1];
  assign ring_left_o        = sp_a_q[0];
  assign ring_left_valid_o  = sp_a_full_q[0];
  assign ring_right_o       = sp_a_q[1];
  assign ring_right_valid_o = sp_a_full_q[1];

`ifdef RING_ROUTER_PERF_CNT_EN
  logic [31:0] perf_fwd_q, perf_stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || conf_accept) begin
      perf_fwd_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      if (sp_pop[dn_sel] && perf_fwd_q != '1) perf_fwd_q <= perf_fwd_q + 32'd1;
      if (sp_a_full_q[dn_sel] && !out_ready[dn_sel] && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fwd_cnt_o   = perf_fwd_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  logic unused_conf_accept;
  assign unused_conf_accept = conf_accept;
`endif

endmodule

// File: tb/tb_ring_router_q.sv
// Scoreboard bench for ring_router_q: directed jobs push expected beats, a negedge monitor pops and compares.
module tb_ring_router_q;
  localparam int DW = 64;
  localparam int LW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          conf_valid_i, conf_ready_o, conf_dir_i;
  logic [1:0]    conf_mode_i;
  logic [LW-1:0] conf_len_i;
  logic          busy_o, done_o;
  logic [DW-1:0] sldu_i, sldu_o;
  logic          sldu_valid_i, sldu_ready_o, sldu_valid_o, sldu_ready_i;
  logic [DW-1:0] ring_left_i, ring_right_i, ring_left_o, ring_right_o;
  logic          ring_left_valid_i, ring_left_ready_o, ring_right_valid_i, ring_right_ready_o;
  logic          ring_left_valid_o, ring_left_ready_i, ring_right_valid_o, ring_right_ready_i;
`ifdef RING_ROUTER_PERF_CNT_EN
  logic [31:0]   perf_fwd_cnt_o, perf_stall_cnt_o;
`endif

  always #5 clk_i = ~clk_i;

  ring_router_q #(.DataWidth(DW), .FifoDepth(4), .LenWidth(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .conf_valid_i(conf_valid_i), .conf_ready_o(conf_ready_o), .conf_dir_i(conf_dir_i),
    .conf_mode_i(conf_mode_i), .conf_len_i(conf_len_i), .busy_o(busy_o), .done_o(done_o),
    .sldu_i(sldu_i), .sldu_valid_i(sldu_valid_i), .sldu_ready_o(sldu_ready_o),
    .sldu_o(sldu_o), .sldu_valid_o(sldu_valid_o), .sldu_ready_i(sldu_ready_i),
    .ring_left_i(ring_left_i), .ring_left_valid_i(ring_left_valid_i), .ring_left_ready_o(ring_left_ready_o),
    .ring_right_i(ring_right_i), .ring_right_valid_i(ring_right_valid_i), .ring_right_ready_o(ring_right_ready_o),
    .ring_left_o(ring_left_o), .ring_left_valid_o(ring_left_valid_o), .ring_left_ready_i(ring_left_ready_i),
    .ring_right_o(ring_right_o), .ring_right_valid_o(ring_right_valid_o), .ring_right_ready_i(ring_right_ready_i)
`ifdef RING_ROUTER_PERF_CNT_EN
    , .perf_fwd_cnt_o(perf_fwd_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = 0;
  int viol_conf = 0;
  int viol_quiet = 0;
  bit quiet_chk = 1'b0;
  logic [DW-1:0] q_left[$], q_right[$], q_sldu[$];

  always @(posedge clk_i) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected beat 0x%0h, nothing expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every output handshake is compared against the head of its expected queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (ring_left_valid_o && ring_left_ready_i) begin
        last_hs = cyc;
        if (q_left.size() == 0) unexpected("left_o", ring_left_o);
        else chk("left_o", ring_left_o, q_left.pop_front());
      end
      if (ring_right_valid_o && ring_right_ready_i) begin
        last_hs = cyc;
        if (q_right.size() == 0) unexpected("right_o", ring_right_o);
        else chk("right_o", ring_right_o, q_right.pop_front());
      end
      if (sldu_valid_o && sldu_ready_i) begin
        last_hs = cyc;
        if (q_sldu.size() == 0) unexpected("sldu_o", sldu_o);
        else chk("sldu_o", sldu_o, q_sldu.pop_front());
      end
      if (busy_o && conf_ready_o) viol_conf++;
      if (quiet_chk && (sldu_valid_o || sldu_ready_o)) viol_quiet++;
    end
  end

  task automatic timeout(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic send_ring_l(input logic [63:0] d);
    bit hs = 1'b0;
    int n = 0;
    ring_left_i = d; ring_left_valid_i = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk_i); hs = ring_left_ready_o;
      @(posedge clk_i); #1; n++;
    end
    ring_left_valid_i = 1'b0;
    if (!hs) timeout("send_ring_l");
  endtask

  task automatic send_ring_r(input logic [63:0] d);
    bit hs = 1'b0;
    int n = 0;
    ring_right_i = d; ring_right_valid_i = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk_i); hs = ring_right_ready_o;
      @(posedge clk_i); #1; n++;
    end
    ring_right_valid_i = 1'b0;
    if (!hs) timeout("send_ring_r");
  endtask

  task automatic send_sldu(input logic [63:0] d);
    bit hs = 1'b0;
    int n = 0;
    sldu_i = d; sldu_valid_i = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk_i); hs = sldu_ready_o;
      @(posedge clk_i); #1; n++;
    end
    sldu_valid_i = 1'b0;
    if (!hs) timeout("send_sldu");
  endtask

  task automatic cfg(input logic dir, input logic [1:0] mode, input logic [15:0] len);
    bit acc = 1'b0;
    int n = 0;
    conf_valid_i = 1'b1; conf_dir_i = dir; conf_mode_i = mode; conf_len_i = len;
    while (!acc && n < 300) begin
      @(negedge clk_i); acc = conf_ready_o;
      @(posedge clk_i); #1; n++;
    end
    conf_valid_i = 1'b0;
    if (!acc) timeout("cfg");
  endtask

  // Returns the cycle in which done_o is seen high, -1 on timeout; leaves time at that negedge.
  task automatic wait_done(input string name, output int dc);
    int n = 0;
    dc = -1;
    while (n < 300) begin
      @(negedge clk_i);
      if (done_o) begin dc = cyc; break; end
      n++;
    end
    if (dc < 0) timeout(name);
  endtask

  task automatic check_done(input string name);
    int dc;
    wait_done(name, dc);
    if (dc >= 0) begin
      chk({name, "_done_lat"}, 64'(dc - last_hs), 64'd1);
      @(negedge clk_i);
      chk({name, "_done_pulse"}, done_o, 1'b0);
    end
    @(posedge clk_i); #1;
  endtask

  initial begin
    int lat, held, dc, lowcnt;
    rst_i = 1'b1;
    conf_valid_i = 0; conf_dir_i = 0; conf_mode_i = 0; conf_len_i = 0;
    sldu_i = 0; sldu_valid_i = 0; sldu_ready_i = 1;
    ring_left_i = 0; ring_left_valid_i = 0; ring_left_ready_i = 1;
    ring_right_i = 0; ring_right_valid_i = 0; ring_right_ready_i = 1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    chk("rst_valids", {ring_left_valid_o, ring_right_valid_o, sldu_valid_o}, 3'b000);
    chk("rst_data", ring_left_o | ring_right_o | sldu_o, 64'd0);
    chk("rst_ctrl", {done_o, busy_o, conf_ready_o, sldu_ready_o, ring_left_ready_o, ring_right_ready_o},
        6'b001011);
`ifdef RING_ROUTER_PERF_CNT_EN
    chk("rst_perf", {perf_fwd_cnt_o, perf_stall_cnt_o}, 64'd0);
`endif
    @(posedge clk_i); #1;

    // LOCAL, dir 0, len 4
    for (int i = 0; i < 4; i++) begin
      q_left.push_back(64'hA0 + 64'(i));
      q_sldu.push_back(64'hB0 + 64'(i));
    end
    cfg(1'b0, 2'b00, 16'd4);
    fork
      begin for (int i = 0; i < 4; i++) send_sldu(64'hA0 + 64'(i)); end
      begin for (int i = 0; i < 4; i++) send_ring_r(64'hB0 + 64'(i)); end
    join
    check_done("local");
    chk("local_left_left", q_left.size(), 0);
    chk("local_sldu_left", q_sldu.size(), 0);

    // BYPASS, dir 1, len 3
    q_right.push_back(64'h11); q_right.push_back(64'h22); q_right.push_back(64'h33);
    cfg(1'b1, 2'b01, 16'd3);
    quiet_chk = 1'b1;
    lat = -1;
    begin
      int c0;
      c0 = cyc;
      fork
        begin send_ring_l(64'h11); send_ring_l(64'h22); send_ring_l(64'h33); end
        begin
          for (int n = 0; n < 20; n++) begin
            @(negedge clk_i);
            if (ring_right_valid_o) begin lat = cyc - c0; break; end
          end
        end
      join
    end
    chk("bypass_latency", 64'(lat), 64'd2);
    check_done("bypass");
    quiet_chk = 1'b0;
    chk("bypass_sldu_quiet", 64'(viol_quiet), 64'd0);
    chk("bypass_right_left", q_right.size(), 0);

    // TEE, dir 0, len 2, SLDU stalls 3 cycles on the first beat
    sldu_ready_i = 1'b0;
    q_left.push_back(64'h5); q_left.push_back(64'h6);
    q_sldu.push_back(64'h5); q_sldu.push_back(64'h6);
    cfg(1'b0, 2'b10, 16'd2);
    held = 0;
    fork
      begin send_ring_r(64'h5); send_ring_r(64'h6); end
      begin
        int n = 0;
        @(negedge clk_i);
        while (!sldu_valid_o && n < 20) begin @(negedge clk_i); n++; end
        for (int j = 0; j < 3; j++) begin
          if (sldu_valid_o && sldu_o == 64'h5) held++;
          if (j < 2) @(negedge clk_i);
        end
        @(posedge clk_i); #1;
        sldu_ready_i = 1'b1;
      end
    join
    chk("tee_sldu_hold", 64'(held), 64'd3);
    check_done("tee");
    chk("tee_left_left", q_left.size(), 0);
    chk("tee_sldu_left", q_sldu.size(), 0);

    // Backpressure: BYPASS dir 0, downstream stalled, 6 beats fill FIFO + spill
    ring_left_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) q_left.push_back(64'hC0 + 64'(i));
    cfg(1'b0, 2'b01, 16'd6);
    for (int i = 0; i < 6; i++) send_ring_r(64'hC0 + 64'(i));
    lowcnt = 0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      if (!ring_right_ready_o && ring_left_valid_o) lowcnt++;
    end
    chk("bp_ready_low", 64'(lowcnt), 64'd3);
    @(posedge clk_i); #1;
    ring_left_ready_i = 1'b1;
    check_done("bp");
    chk("bp_left_left", q_left.size(), 0);

    // Config request held while a job is running, then a len-0 job
    q_left.push_back(64'hD0); q_left.push_back(64'hD1);
    cfg(1'b0, 2'b01, 16'd2);
    conf_valid_i = 1'b1; conf_dir_i = 1'b0; conf_mode_i = 2'b00; conf_len_i = 16'd0;
    send_ring_r(64'hD0); send_ring_r(64'hD1);
    wait_done("cfg_job1", dc);
    chk("cfg_ready_at_done", conf_ready_o, 1'b0);
    @(negedge clk_i);
    chk("cfg_ready_idle", {conf_ready_o, done_o}, 2'b10);
    @(posedge clk_i); #1;
    conf_valid_i = 1'b0;
    @(negedge clk_i);
    chk("len0_done", {done_o, busy_o}, 2'b10);
    chk("len0_no_traffic", {ring_left_valid_o, ring_right_valid_o, sldu_valid_o}, 3'b000);
    @(negedge clk_i);
    chk("len0_done_pulse", done_o, 1'b0);
    chk("cfg_left_left", q_left.size(), 0);
    @(posedge clk_i); #1;

    // Reset mid-job with queued beats
    ring_left_ready_i = 1'b0;
    cfg(1'b0, 2'b01, 16'd8);
    send_ring_r(64'hE0); send_ring_r(64'hE1); send_ring_r(64'hE2);
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid_valids", {ring_left_valid_o, ring_right_valid_o, sldu_valid_o}, 3'b000);
    chk("rst_mid_ctrl", {busy_o, conf_ready_o, ring_left_ready_o, ring_right_ready_o}, 4'b0111);
`ifdef RING_ROUTER_PERF_CNT_EN
    chk("rst_mid_perf", {perf_fwd_cnt_o, perf_stall_cnt_o}, 64'd0);
`endif
    @(posedge clk_i); #1;
    ring_left_ready_i = 1'b1;
    q_left.push_back(64'h77);
    cfg(1'b0, 2'b01, 16'd1);
    send_ring_r(64'h77);
    check_done("post_rst");
    chk("post_rst_left_left", q_left.size(), 0);

    chk("conf_ready_while_busy", 64'(viol_conf), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
